// File: rtl/spi_master_ctrl.sv
// SPI master: sends one 11-bit command/payload frame per start request and
// captures an 8-bit reply for read-data frames. Optional macro: SPI_MASTER_OVERRUN_EN.
module spi_master_ctrl #(
  parameter int unsigned RD_TURNAROUND = 2,
  parameter int unsigned GAP_CYCLES    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [7:0] tx_data,
  input  logic       miso,
  output logic       mosi,
  output logic       ss_n,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       rd_valid
`ifdef SPI_MASTER_OVERRUN_EN
  ,
  output logic       overrun
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEL   = 3'd1,
    SHIFT = 3'd2,
    WAIT  = 3'd3,
    RECV  = 3'd4,
    GAP   = 3'd5
  } state_t;

  localparam logic [1:0] CMD_RD_DATA = 2'b11;
  localparam logic [3:0] SHIFT_LOAD  = 4'd10;
  localparam logic [3:0] RECV_LOAD   = 4'd7;
  localparam logic [3:0] WAIT_LOAD   = 4'(RD_TURNAROUND - 1);
  localparam logic [3:0] GAP_LOAD    = 4'(GAP_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [1:0]  sh_cmd;
  logic [10:0] tx_sr;
  logic [7:0]  rx_sr;

  // Handshake: start is a level sampled only while state is IDLE; the frame
  // ends with done (and rd_valid for read-data) high for exactly one cycle.
  // cnt counts remaining cycles of the current state and is reloaded on entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      sh_cmd   <= 2'b00;
      tx_sr    <= 11'd0;
      rx_sr    <= 8'd0;
      mosi     <= 1'b0;
      ss_n     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= 8'h00;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sh_cmd <= cmd;
            // Route bit duplicates cmd[1]; the slave sees the last 10 bits.
            tx_sr  <= {cmd[1], cmd[1], cmd[0], tx_data};
            state  <= SEL;
            cnt    <= 4'd0;
            ss_n   <= 1'b0;
            busy   <= 1'b1;
            mosi   <= 1'b0;
          end
        end
        SEL: begin
          state <= SHIFT;
          cnt   <= SHIFT_LOAD;
          mosi  <= tx_sr[10];
          tx_sr <= {tx_sr[9:0], 1'b0};
        end
        SHIFT: begin
          if (cnt != 4'd0) begin
            cnt   <= cnt - 4'd1;
            mosi  <= tx_sr[10];
            tx_sr <= {tx_sr[9:0], 1'b0};
          end else begin
            mosi <= 1'b0;
            if (sh_cmd == CMD_RD_DATA) begin
              state <= WAIT;
              cnt   <= WAIT_LOAD;
            end else begin
              state <= GAP;
              cnt   <= GAP_LOAD;
              ss_n  <= 1'b1;
              done  <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= RECV;
            cnt   <= RECV_LOAD;
          end
        end
        RECV: begin
          rx_sr <= {rx_sr[6:0], miso};
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state    <= GAP;
            cnt      <= GAP_LOAD;
            ss_n     <= 1'b1;
            done     <= 1'b1;
            rd_valid <= 1'b1;
            rd_data  <= {rx_sr[6:0], miso};
          end
        end
        GAP: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
          ss_n  <= 1'b1;
          mosi  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPI_MASTER_OVERRUN_EN
  // Sticky flag for any request that arrives while a frame is in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (start && busy) begin
      overrun <= 1'b1;
    end
  end
`endif

endmodule
